mem_stage: RTL and testbench

//  MEM pipeline stage of the 5-stage CPU; consumes the EX/MEM register outputs directly.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_stage_mem_wb_reg.sv | 84 ++++++++
 rtl/mem_stage.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and defaults for the MEM pipeline stage.
//   state_e    : MEM stage FSM states (IDLE, BUSY, DONE)
//   DATA_W_DEF : default data/address width
//   RD_W_DEF   : default destination register index width
//   TIMEOUT_DEF: default BUSY cycle limit before forced completion
//   cnt_width(): width of the BUSY cycle counter for a given timeout
// -----------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int RD_W_DEF    = 5;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register.
//   clk_i, rst_i      : clock (rising edge), asynchronous active-low reset
//   load_i            : capture new contents at the next edge (else hold)
//   bubble_i          : when loading, capture an all-zero bubble instead
//   memtoreg_i/_o     : writeback selects load data
//   regwrite_i/_o     : register file write enable
//   result_i/_o       : ALU result
//   rdata_i/_o        : load data
//   rd_i/_o           : destination register index
// -----------------------------------------------------------------------------
module mem_wb_reg #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              bubble_i,
   input  logic              memtoreg_i,
   input  logic              regwrite_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [RD_W-1:0]   rd_i,
   output logic              memtoreg_o,
   output logic              regwrite_o,
   output logic [DATA_W-1:0] result_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic [RD_W-1:0]   rd_o
);

   logic              memtoreg_q, memtoreg_d;
   logic              regwrite_q, regwrite_d;
   logic [DATA_W-1:0] result_q,   result_d;
   logic [DATA_W-1:0] rdata_q,    rdata_d;
   logic [RD_W-1:0]   rd_q,       rd_d;

   always_comb begin
      memtoreg_d = memtoreg_q;
      regwrite_d = regwrite_q;
      result_d   = result_q;
      rdata_d    = rdata_q;
      rd_d       = rd_q;
      if (load_i) begin
         if (bubble_i) begin
            memtoreg_d = 1'b0;
            regwrite_d = 1'b0;
            result_d   = '0;
            rdata_d    = '0;
            rd_d       = '0;
         end else begin
            memtoreg_d = memtoreg_i;
            regwrite_d = regwrite_i;
            result_d   = result_i;
            rdata_d    = rdata_i;
            rd_d       = rd_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         memtoreg_q <= 1'b0;
         regwrite_q <= 1'b0;
         result_q   <= '0;
         rdata_q    <= '0;
         rd_q       <= '0;
      end else begin
         memtoreg_q <= memtoreg_d;
         regwrite_q <= regwrite_d;
         result_q   <= result_d;
         rdata_q    <= rdata_d;
         rd_q       <= rd_d;
      end
   end

   assign memtoreg_o = memtoreg_q;
   assign regwrite_o = regwrite_q;
   assign result_o   = result_q;
   assign rdata_o    = rdata_q;
   assign rd_o       = rd_q;

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM stage of the 5-stage pipeline. Takes the EX/MEM register outputs,
// performs loads/stores on a multi-cycle data memory over a req/ack
// handshake (stalling upstream while the access is in flight) and drives
// the WB stage through the MEM/WB register. Non-memory instructions pass
// through with one cycle of latency.
//
// Ports
//   clk_i, rst_i        : clock (rising edge), asynchronous active-low reset
//   memtoreg_i          : instruction is a load
//   regwrite_i          : instruction writes the register file
//   memwrite_i          : instruction is a store
//   result_i            : ALU result / byte address
//   data_i              : store data
//   RD_i                : destination register
//   stall_o             : freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//   mem_req_o/_we_o     : registered memory request / write enable
//   mem_addr_o/_wdata_o : address and write data, stable while requesting
//   mem_ack_i           : memory done, mem_rdata_i valid in the same cycle
//   mem_rdata_i         : memory read data
//   memtoreg_o .. RD_o  : MEM/WB register outputs
//   bus_err_o           : sticky, a request timed out
//   misalign_o          : one-cycle pulse when a misaligned access is dropped
//
// Build option
//   MEM_MISALIGN_CHK_EN : when defined, word accesses with result_i[1:0]!=0
//                         issue no request and retire with the register
//                         write suppressed; when undefined the address is
//                         passed through unchecked and misalign_o is 0.
// -----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RD_W    = RD_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              memtoreg_i,
   input  logic              regwrite_i,
   input  logic              memwrite_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [RD_W-1:0]   RD_i,
   output logic              stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              memtoreg_o,
   output logic              regwrite_o,
   output logic [DATA_W-1:0] result_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic [RD_W-1:0]   RD_o,
   output logic              bus_err_o,
   output logic              misalign_o
);

   localparam int CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              req_q,   req_d;
   logic              we_q,    we_d;
   logic [DATA_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              bus_err_q, bus_err_d;
   logic              mis_q,   mis_d;

   logic              access;
   logic              misaligned;
   logic              stall_raw;
   logic              wb_load;
   logic              wb_bubble;
   logic              wb_regwrite;
   logic [DATA_W-1:0] wb_rdata;

   assign access = memtoreg_i | memwrite_i;

`ifdef MEM_MISALIGN_CHK_EN
   assign misaligned = access & (result_i[1:0] != 2'b00);
   assign misalign_o = mis_q;
`else
   assign misaligned = 1'b0;
   assign misalign_o = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      bus_err_d   = bus_err_q;
      mis_d       = 1'b0;
      stall_raw   = 1'b0;
      wb_load     = 1'b1;
      wb_bubble   = 1'b0;
      wb_regwrite = regwrite_i;
      wb_rdata    = '0;

      unique case (state_q)
         IDLE: begin
            if (access) begin
               // Hold EX/MEM and send a bubble to WB while the access runs.
               stall_raw = 1'b1;
               wb_bubble = 1'b1;
               addr_d    = result_i;
               wdata_d   = data_i;
               we_d      = memwrite_i;
               cnt_d     = '0;
               rdata_d   = '0;
               if (misaligned) begin
                  mis_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  req_d   = 1'b1;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            // MEM/WB keeps the bubble loaded on entry.
            stall_raw = 1'b1;
            wb_load   = 1'b0;
            if (mem_ack_i) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               rdata_d = we_q ? '0 : mem_rdata_i;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               req_d     = 1'b0;
               cnt_d     = '0;
               bus_err_d = 1'b1;
               rdata_d   = '0;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            // EX/MEM still presents the stalled instruction; retire it now.
            wb_rdata    = rdata_q;
            wb_regwrite = regwrite_i & ~mis_q;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         bus_err_q <= bus_err_d;
         mis_q     <= mis_d;
      end
   end

   // Upstream registers are also in reset, so never hold them frozen then.
   assign stall_o     = stall_raw & rst_i;
   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign bus_err_o   = bus_err_q;

   mem_wb_reg #(
      .DATA_W (DATA_W),
      .RD_W   (RD_W)
   ) u_mem_wb_reg (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (wb_load),
      .bubble_i   (wb_bubble),
      .memtoreg_i (memtoreg_i),
      .regwrite_i (wb_regwrite),
      .result_i   (result_i),
      .rdata_i    (wb_rdata),
      .rd_i       (RD_i),
      .memtoreg_o (memtoreg_o),
      .regwrite_o (regwrite_o),
      .result_o   (result_o),
      .rdata_o    (rdata_o),
      .rd_o       (RD_o)
   );

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage (TIMEOUT=4). Expected MEM/WB writebacks are
// queued when an instruction is issued; a monitor pops and compares them
// whenever MEM/WB presents a live instruction. A memory responder acks
// after a programmable number of BUSY cycles and checks request stability.
// -----------------------------------------------------------------------------
module tb_mem_stage;

   localparam int DW  = 32;
   localparam int RW  = 5;
   localparam int TO  = 4;
   localparam logic [DW-1:0] GARBAGE = 32'h5A5A_5A5A;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          memtoreg_i, regwrite_i, memwrite_i;
   logic [DW-1:0] result_i, data_i;
   logic [RW-1:0] RD_i;
   logic          stall_o, mem_req_o, mem_we_o;
   logic [DW-1:0] mem_addr_o, mem_wdata_o;
   logic          mem_ack_i;
   logic [DW-1:0] mem_rdata_i;
   logic          memtoreg_o, regwrite_o;
   logic [DW-1:0] result_o, rdata_o;
   logic [RW-1:0] RD_o;
   logic          bus_err_o, misalign_o;

   mem_stage #(.DATA_W(DW), .RD_W(RW), .TIMEOUT(TO)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .memtoreg_i  (memtoreg_i),
      .regwrite_i  (regwrite_i),
      .memwrite_i  (memwrite_i),
      .result_i    (result_i),
      .data_i      (data_i),
      .RD_i        (RD_i),
      .stall_o     (stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .memtoreg_o  (memtoreg_o),
      .regwrite_o  (regwrite_o),
      .result_o    (result_o),
      .rdata_o     (rdata_o),
      .RD_o        (RD_o),
      .bus_err_o   (bus_err_o),
      .misalign_o  (misalign_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic          m2r;
      logic          rw;
      logic [DW-1:0] res;
      logic [DW-1:0] rdata;
      logic [RW-1:0] rd;
   } wb_t;

   wb_t exp_q[$];

   int checks   = 0;
   int failures = 0;

   // responder control / observation
   int            ack_delay = -1;
   logic [DW-1:0] ack_data  = '0;
   logic [DW-1:0] exp_addr  = '0;
   logic [DW-1:0] exp_wdata = '0;
   logic          exp_we    = 1'b0;
   int            busy_idx  = 0;
   int            req_cycles = 0;
   int            mis_cnt   = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
      end
   endtask

   // Memory responder: acks in BUSY cycle number ack_delay (0 = first).
   always @(posedge clk_i) begin
      #1;
      if (mem_req_o === 1'b1) begin
         chk("req_addr", mem_addr_o, exp_addr);
         chk("req_we", {31'd0, mem_we_o}, {31'd0, exp_we});
         if (exp_we) chk("req_wdata", mem_wdata_o, exp_wdata);
         mem_ack_i   = (busy_idx == ack_delay);
         mem_rdata_i = (busy_idx == ack_delay) ? ack_data : GARBAGE;
         busy_idx++;
         req_cycles++;
      end else begin
         busy_idx    = 0;
         mem_ack_i   = 1'b0;
         mem_rdata_i = GARBAGE;
      end
   end

   always @(negedge clk_i) begin
      if (rst_i === 1'b1 && misalign_o === 1'b1) mis_cnt++;
   end

   // Scoreboard monitor: a live MEM/WB entry is one with regwrite or memtoreg.
   always @(negedge clk_i) begin
      wb_t e;
      if (rst_i === 1'b1 && (regwrite_o === 1'b1 || memtoreg_o === 1'b1)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_wb actual=rw%0b/m2r%0b/rd%0d required=no_writeback t=%0t",
                     regwrite_o, memtoreg_o, RD_o, $time);
         end else begin
            e = exp_q.pop_front();
            $display("WB  rd=%0d rw=%0b m2r=%0b result=0x%08h rdata=0x%08h", RD_o, regwrite_o,
                     memtoreg_o, result_o, rdata_o);
            chk("wb_memtoreg", {31'd0, memtoreg_o}, {31'd0, e.m2r});
            chk("wb_regwrite", {31'd0, regwrite_o}, {31'd0, e.rw});
            chk("wb_result", result_o, e.res);
            chk("wb_rdata", rdata_o, e.rdata);
            chk("wb_rd", {27'd0, RD_o}, {27'd0, e.rd});
         end
      end
   end

   task automatic drive_nop();
      memtoreg_i = 1'b0; regwrite_i = 1'b0; memwrite_i = 1'b0;
      result_i = '0; data_i = '0; RD_i = '0;
   endtask

   // Present one instruction as EX/MEM would, holding it while stall_o=1.
   task automatic send(input logic m2r, input logic rw, input logic mw,
                       input logic [DW-1:0] res, input logic [DW-1:0] dat,
                       input logic [RW-1:0] rd, input int delay,
                       input logic [DW-1:0] ackd, output int stalls);
      bit accepted;
      ack_delay = delay; ack_data = ackd;
      exp_addr = res; exp_wdata = dat; exp_we = mw;
      memtoreg_i = m2r; regwrite_i = rw; memwrite_i = mw;
      result_i = res; data_i = dat; RD_i = rd;
      stalls = 0;
      accepted = 1'b0;
      for (int c = 0; c < 64 && !accepted; c++) begin
         @(negedge clk_i);
         if (stall_o === 1'b1) stalls++;
         else accepted = 1'b1;
         @(posedge clk_i); #1;
      end
      if (!accepted) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=stalled required=accepted_within_64 t=%0t", $time);
      end
      $display("TXN m2r=%0b rw=%0b we=%0b addr=0x%08h rd=%0d stalls=%0d req_cycles=%0d",
               m2r, rw, mw, res, rd, stalls, req_cycles);
      drive_nop();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      rst_i = 1'b0;
      mem_ack_i = 1'b0;
      mem_rdata_i = GARBAGE;
      drive_nop();
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_regwrite", {31'd0, regwrite_o}, 32'd0);
      chk("rst_memtoreg", {31'd0, memtoreg_o}, 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
      chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      // ALU ops, back to back
      exp_q.push_back('{m2r:1'b0, rw:1'b1, res:32'h10, rdata:32'h0, rd:5'd5});
      req_cycles = 0;
      send(1'b0, 1'b1, 1'b0, 32'h10, 32'hFFFF_0000, 5'd5, -1, 32'h0, st);
      chk("alu_stalls", st, 0);
      exp_q.push_back('{m2r:1'b0, rw:1'b1, res:32'hABCD_0123, rdata:32'h0, rd:5'd31});
      send(1'b0, 1'b1, 1'b0, 32'hABCD_0123, 32'h0, 5'd31, -1, 32'h0, st);
      chk("alu2_stalls", st, 0);
      chk("alu_no_req", req_cycles, 0);

      // Load, ack in first BUSY cycle
      exp_q.push_back('{m2r:1'b1, rw:1'b1, res:32'h40, rdata:32'hDEAD_BEEF, rd:5'd7});
      req_cycles = 0;
      send(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 0, 32'hDEAD_BEEF, st);
      chk("load_stalls", st, 2);
      chk("load_req_cycles", req_cycles, 1);

      // Store, ack in third BUSY cycle
      req_cycles = 0;
      send(1'b0, 1'b0, 1'b1, 32'h8, 32'h1234, 5'd2, 2, 32'hFFFF_FFFF, st);
      chk("store_stalls", st, 4);
      chk("store_req_cycles", req_cycles, 3);
      chk("store_regwrite", {31'd0, regwrite_o}, 32'd0);
      chk("store_rdata", rdata_o, 32'd0);

      // Load that never gets an ack: forced completion after TO BUSY cycles
      exp_q.push_back('{m2r:1'b1, rw:1'b1, res:32'h20, rdata:32'h0, rd:5'd9});
      req_cycles = 0;
      send(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd9, -1, 32'h0, st);
      chk("timeout_stalls", st, TO + 1);
      chk("timeout_req_cycles", req_cycles, TO);
      chk("timeout_bus_err", {31'd0, bus_err_o}, 32'd1);
      exp_q.push_back('{m2r:1'b0, rw:1'b1, res:32'h77, rdata:32'h0, rd:5'd1});
      send(1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 5'd1, -1, 32'h0, st);
      chk("resume_stalls", st, 0);
      chk("bus_err_sticky", {31'd0, bus_err_o}, 32'd1);

      // Reset while BUSY
      ack_delay = -1; exp_addr = 32'h30; exp_we = 1'b0;
      memtoreg_i = 1'b1; regwrite_i = 1'b1; result_i = 32'h30; RD_i = 5'd4;
      @(posedge clk_i); #1;
      chk("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
      chk("midrst_stall", {31'd0, stall_o}, 32'd0);
      chk("midrst_bus_err", {31'd0, bus_err_o}, 32'd0);
      drive_nop();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      exp_q.push_back('{m2r:1'b0, rw:1'b1, res:32'h55, rdata:32'h0, rd:5'd6});
      send(1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 5'd6, -1, 32'h0, st);
      chk("post_rst_stalls", st, 0);

      // Misaligned load
      req_cycles = 0;
      mis_cnt = 0;
`ifdef MEM_MISALIGN_CHK_EN
      exp_q.push_back('{m2r:1'b1, rw:1'b0, res:32'h41, rdata:32'h0, rd:5'd3});
      send(1'b1, 1'b1, 1'b0, 32'h41, 32'h0, 5'd3, 0, 32'hCAFE_F00D, st);
      chk("mis_stalls", st, 1);
      chk("mis_req_cycles", req_cycles, 0);
      chk("mis_pulses", mis_cnt, 1);
`else
      exp_q.push_back('{m2r:1'b1, rw:1'b1, res:32'h41, rdata:32'hCAFE_F00D, rd:5'd3});
      send(1'b1, 1'b1, 1'b0, 32'h41, 32'h0, 5'd3, 0, 32'hCAFE_F00D, st);
      chk("mis_stalls", st, 2);
      chk("mis_req_cycles", req_cycles, 1);
      chk("mis_pulses", mis_cnt, 0);
`endif

      repeat (4) @(posedge clk_i);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
